dmux_stream: RTL and testbench

//  Registered, handshaked 1-to-2^S demultiplexer; next generation of the dmux family.

---
 rtl/dmux_stream.sv | 120 ++++++++++++
 tb/tb_dmux_stream.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dmux_stream.sv
// dmux_stream: registered, handshaked 1-to-2**S demultiplexer.
//   A word on d is routed to channel s (or to every channel when bcast=1).
//   Each channel has a one-entry output register with its own valid/ready
//   handshake, so a stalled consumer only blocks words addressed to it.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   d, s, bcast       input word, destination channel, broadcast flag
//   d_valid/d_ready   producer handshake (d_ready is combinational)
//   y, y_valid        per-channel data (channel i = y[i*N +: N]) and valid
//   y_ready           per-channel consumer ready
//   acc_cnt           accepted-transfer counter, wraps modulo 2**CW
//   busy              any channel holding a word

// One output channel: a single-entry register with valid/ready handshake.
module dmux_stream_chan #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,     // accepted word targets this channel
  input  logic [N-1:0] d,
  input  logic         y_ready,
  output logic [N-1:0] y,
  output logic         y_valid,
  output logic         free      // can take a word this cycle
);
  logic [N-1:0] y_q, y_d;
  logic         vld_q, vld_d;

  // A channel that drains this cycle may be reloaded in the same cycle.
  assign free = ~vld_q | y_ready;

  always_comb begin
    y_d   = y_q;
    vld_d = vld_q;
    if (load) begin
      // load wins over a simultaneous drain
      y_d   = d;
      vld_d = 1'b1;
    end else if (vld_q && y_ready) begin
      vld_d = 1'b0;  // data left stale on purpose
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign y       = y_q;
  assign y_valid = vld_q;
endmodule

module dmux_stream #(
  parameter int N  = 6,
  parameter int S  = 3,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      d,
  input  logic [S-1:0]      s,
  input  logic              bcast,
  input  logic              d_valid,
  output logic              d_ready,
  output logic [(2**S)*N-1:0] y,
  output logic [(2**S)-1:0] y_valid,
  input  logic [(2**S)-1:0] y_ready,
  output logic [CW-1:0]     acc_cnt,
  output logic              busy
);
  localparam int M = 2 ** S;

  logic [M-1:0]  free;
  logic [M-1:0]  load;
  logic          accept;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;

  // Broadcast is all-or-nothing, so it needs every channel free.
  assign d_ready = bcast ? (&free) : free[s];
  assign accept  = d_valid & d_ready;

  always_comb begin
    load = '0;
    for (int i = 0; i < M; i++)
      load[i] = accept & (bcast | (s == S'(i)));
  end

  for (genvar g = 0; g < M; g++) begin : g_chan
    dmux_stream_chan #(.N(N)) u_chan (
      .clk    (clk),
      .reset  (reset),
      .load   (load[g]),
      .d      (d),
      .y_ready(y_ready[g]),
      .y      (y[g*N +: N]),
      .y_valid(y_valid[g]),
      .free   (free[g])
    );
  end

  // A broadcast counts as a single accepted transfer.
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (accept) acc_cnt_d = acc_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) acc_cnt_q <= '0;
    else       acc_cnt_q <= acc_cnt_d;
  end

  assign acc_cnt = acc_cnt_q;
  assign busy    = |y_valid;
endmodule

// File: tb/tb_dmux_stream.sv
module tb_dmux_stream;
  localparam int N  = 6;
  localparam int S  = 3;
  localparam int CW = 8;
  localparam int M  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   d;
  logic [S-1:0]   s;
  logic           bcast;
  logic           d_valid;
  logic           d_ready;
  logic [M*N-1:0] y;
  logic [M-1:0]   y_valid;
  logic [M-1:0]   y_ready;
  logic [CW-1:0]  acc_cnt;
  logic           busy;

  dmux_stream #(.N(N), .S(S), .CW(CW)) dut (
    .clk(clk), .reset(reset), .d(d), .s(s), .bcast(bcast),
    .d_valid(d_valid), .d_ready(d_ready), .y(y), .y_valid(y_valid),
    .y_ready(y_ready), .acc_cnt(acc_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference state
  logic [N-1:0]  m_y [M];
  logic [M-1:0]  m_v;
  logic [CW-1:0] m_cnt;

  typedef struct {
    logic [M-1:0]   yv;
    logic [M*N-1:0] yd;
    logic [CW-1:0]  cnt;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [N-1:0] d;
    logic [S-1:0] s;
    logic         bc;
    logic         dv;
    logic [M-1:0] yr;
    logic         exp_dr;
    logic [M-1:0] exp_yv;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++) m_y[i] = '0;
    m_v   = '0;
    m_cnt = '0;
  endtask

  // Drive one cycle, check d_ready against the model, push the expected
  // post-edge state and compare it after the edge.
  task automatic apply(input logic [N-1:0] dd, input logic [S-1:0] ss, input logic bb,
                       input logic dv, input logic [M-1:0] yr);
    logic [M-1:0]   mf;
    logic           mdr, acc;
    exp_t           e, g;
    @(negedge clk);
    d = dd; s = ss; bcast = bb; d_valid = dv; y_ready = yr;
    #1;
    for (int i = 0; i < M; i++) mf[i] = ~m_v[i] | yr[i];
    mdr = bb ? (mf == '1) : mf[ss];
    chk("d_ready_model", {63'd0, d_ready}, {63'd0, mdr});
    acc = dv & mdr;
    for (int i = 0; i < M; i++) begin
      if (acc && (bb || ss == i)) begin
        m_y[i] = dd; m_v[i] = 1'b1;
      end else if (m_v[i] && yr[i]) begin
        m_v[i] = 1'b0;
      end
    end
    if (acc) m_cnt = m_cnt + 1'b1;
    e.yv = m_v; e.cnt = m_cnt;
    for (int i = 0; i < M; i++) e.yd[i*N +: N] = m_y[i];
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      g = sb.pop_front();
      chk("y_valid", {56'd0, y_valid}, {56'd0, g.yv});
      chk("y", {16'd0, y}, {16'd0, g.yd});
      chk("acc_cnt", {56'd0, acc_cnt}, {56'd0, g.cnt});
      chk("busy", {63'd0, busy}, {63'd0, |g.yv});
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; d_valid = 1'b1; d = 6'h3F; s = 3'd1; bcast = 1'b0; y_ready = '0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    chk("rst_y_valid", {56'd0, y_valid}, 64'd0);
    chk("rst_y", {16'd0, y}, 64'd0);
    chk("rst_acc_cnt", {56'd0, acc_cnt}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0; d_valid = 1'b0;
  endtask

  vec_t vt[15];

  initial begin
    reset = 1'b0; d = '0; s = '0; bcast = 1'b0; d_valid = 1'b0; y_ready = '0;
    model_reset();

    //        d      s  bc  dv  yr     dr  yv     cnt
    vt[0]  = '{6'h2A, 5, 0, 1, 8'h00, 1, 8'h20, 8'd1};
    vt[1]  = '{6'h11, 5, 0, 1, 8'h00, 0, 8'h20, 8'd1};
    vt[2]  = '{6'h0C, 2, 0, 1, 8'h00, 1, 8'h24, 8'd2};
    vt[3]  = '{6'h01, 3, 0, 1, 8'h08, 1, 8'h2C, 8'd3};
    vt[4]  = '{6'h02, 3, 0, 1, 8'h08, 1, 8'h2C, 8'd4};
    vt[5]  = '{6'h03, 3, 0, 1, 8'h08, 1, 8'h2C, 8'd5};
    vt[6]  = '{6'h00, 0, 0, 0, 8'hFF, 1, 8'h00, 8'd5};
    vt[7]  = '{6'h07, 7, 0, 1, 8'h00, 1, 8'h80, 8'd6};
    vt[8]  = '{6'h15, 0, 1, 1, 8'h00, 0, 8'h80, 8'd6};
    vt[9]  = '{6'h15, 0, 1, 1, 8'h80, 1, 8'hFF, 8'd7};
    vt[10] = '{6'h3F, 0, 0, 1, 8'h01, 1, 8'hFF, 8'd8};
    vt[11] = '{6'h2B, 4, 1, 1, 8'hFF, 1, 8'hFF, 8'd9};
    vt[12] = '{6'h05, 6, 0, 1, 8'h00, 0, 8'hFF, 8'd9};
    vt[13] = '{6'h05, 6, 0, 0, 8'h40, 1, 8'hBF, 8'd9};
    vt[14] = '{6'h05, 6, 0, 1, 8'h00, 1, 8'hFF, 8'd10};

    do_reset(2);

    for (int i = 0; i < 15; i++) begin
      apply(vt[i].d, vt[i].s, vt[i].bc, vt[i].dv, vt[i].yr);
      chk($sformatf("vec%0d_y_valid", i), {56'd0, y_valid}, {56'd0, vt[i].exp_yv});
      chk($sformatf("vec%0d_acc_cnt", i), {56'd0, acc_cnt}, {56'd0, vt[i].exp_cnt});
      if (i == 0)  chk("unicast_y5", {58'd0, y[5*N +: N]}, 64'h2A);
      if (i == 5)  chk("pass_y3", {58'd0, y[3*N +: N]}, 64'h03);
      if (i == 9)  chk("bcast_y", {16'd0, y}, {16'd0, {8{6'h15}}});
      if (i == 10) chk("drain_load_y0", {58'd0, y[0 +: N]}, 64'h3F);
    end
    // d_ready for the table rows, re-sampled with the row's inputs against
    // the hand-derived value (state before the row is rebuilt by replay).
    do_reset(1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      d = vt[i].d; s = vt[i].s; bcast = vt[i].bc; d_valid = vt[i].dv; y_ready = vt[i].yr;
      #1;
      chk($sformatf("vec%0d_d_ready", i), {63'd0, d_ready}, {63'd0, vt[i].exp_dr});
      @(posedge clk);
    end

    // Counter wrap: 256 accepts after reset bring acc_cnt back to 0.
    do_reset(1);
    for (int i = 0; i < 256; i++)
      apply(N'(i), S'(i), 1'b0, 1'b1, 8'hFF);
    chk("wrap_acc_cnt", {56'd0, acc_cnt}, 64'd0);

    // Mid-operation reset with channels 1 and 4 holding words.
    apply(6'h00, 0, 1'b0, 1'b0, 8'hFF);
    apply(6'h09, 1, 1'b0, 1'b1, 8'h00);
    apply(6'h24, 4, 1'b0, 1'b1, 8'h00);
    chk("pre_rst_y_valid", {56'd0, y_valid}, 64'h12);
    chk("pre_rst_acc_cnt", {56'd0, acc_cnt}, 64'd2);
    do_reset(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
